jk_excitation_driver: RTL

//  Drive side of the JK flip-flop interface: turns counter commands (hold/up/down/load)

---
 rtl/jk_excitation_driver_if.sv | 29 ++
 rtl/jk_excitation_driver.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver_if.sv
// Bundles the command handshake and the JK bank excitation/feedback signals of
// jk_excitation_driver. The master side is the counter control logic together
// with the JK bank; the slave side is the excitation driver itself.
interface jk_excitation_driver_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             load_err;
  logic             mismatch;
  logic             err_clr;

  modport master (
    output cmd_valid, cmd_op, cmd_data, q_fb, err_clr,
    input  cmd_ready, j, k, count, wrap, load_err, mismatch
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, q_fb, err_clr,
    output cmd_ready, j, k, count, wrap, load_err, mismatch
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: turns hold/up/down/load commands into registered J/K
// excitation for an external bank of WIDTH JK flops, keeps a shadow copy of the
// bank state and checks the bank's Q feedback after every step.
// Each command takes three cycles: IDLE (accept) -> DRIVE (bank moves) -> CHECK.
// Optional build macro JK_TOGGLE_EN: changing bits are driven with J=K=1 (toggle)
// instead of the default set/reset coding.
module jk_excitation_driver #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  jk_excitation_driver_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             wrap_pend_q, wrap_pend_d;
  logic             load_err_q, load_err_d;
  logic             mismatch_q, mismatch_d;

  logic             accept;
  logic             fb_ok;
  logic [WIDTH-1:0] next_val;
  logic             next_wrap;
  logic             load_bad;
  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;

  assign accept = bus.cmd_valid && (state_q == ST_IDLE);
  assign fb_ok  = (bus.q_fb == target_q);

  // Next counter value for the offered command; an out-of-range load degrades to hold.
  always_comb begin
    next_val  = count_q;
    next_wrap = 1'b0;
    load_bad  = 1'b0;
    case (bus.cmd_op)
      2'b01: begin
        if (count_q == MAX_VAL) begin
          next_val  = '0;
          next_wrap = 1'b1;
        end else begin
          next_val  = count_q + 1'b1;
        end
      end
      2'b10: begin
        if (count_q == '0) begin
          next_val  = MAX_VAL;
          next_wrap = 1'b1;
        end else begin
          next_val  = count_q - 1'b1;
        end
      end
      2'b11: begin
        if ({1'b0, bus.cmd_data} >= MOD_EXT) begin
          load_bad = 1'b1;
        end else begin
          next_val = bus.cmd_data;
        end
      end
      default: next_val = count_q;
    endcase
  end

  // Per-bit excitation moving the bank from count_q to next_val.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_exc
`ifdef JK_TOGGLE_EN
    assign exc_j[gi] = count_q[gi] ^ next_val[gi];
    assign exc_k[gi] = count_q[gi] ^ next_val[gi];
`else
    assign exc_j[gi] = ~count_q[gi] &  next_val[gi];
    assign exc_k[gi] =  count_q[gi] & ~next_val[gi];
`endif
  end

  // Next-state logic: command accept, single drive cycle, feedback check and resync.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    target_d    = target_q;
    j_d         = '0;
    k_d         = '0;
    wrap_pend_d = wrap_pend_q;
    load_err_d  = 1'b0;
    mismatch_d  = mismatch_q & ~bus.err_clr;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          target_d    = next_val;
          wrap_pend_d = next_wrap;
          load_err_d  = load_bad;
          j_d         = exc_j;
          k_d         = exc_k;
          state_d     = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (fb_ok) begin
          count_d = target_q;
        end else begin
          count_d    = bus.q_fb;
          mismatch_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset forces j/k low immediately to abort a step.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      target_q    <= '0;
      j_q         <= '0;
      k_q         <= '0;
      wrap_pend_q <= 1'b0;
      load_err_q  <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      target_q    <= target_d;
      j_q         <= j_d;
      k_q         <= k_d;
      wrap_pend_q <= wrap_pend_d;
      load_err_q  <= load_err_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.count     = count_q;
  assign bus.load_err  = load_err_q;
  // A failing check is visible in CHECK itself and stays sticky afterwards.
  assign bus.mismatch  = mismatch_q | ((state_q == ST_CHECK) & ~fb_ok);
  assign bus.wrap      = (state_q == ST_CHECK) & wrap_pend_q & fb_ok;

endmodule
